mt32_i2s_rx: RTL
================

// Module: mt32_i2s_rx
// PURPOSE
//  I2S receiver for the MT32-pi audio path. Consumes the already-routed bclk/ws/data user-port pins
//  and delivers signed stereo sample pairs to AUDIO_L/AUDIO_R, with a one-cycle sample strobe.
//  Adds glitch filtering, word-length checking, lock tracking and mute-on-loss. Runs on CLK_AUDIO.
// PARAMETERS
//  DATA_W       16    sample width; bits beyond DATA_W in a slot are dropped
//  TIMEOUT_CYC  4096  clk cycles without a bclk rising edge before mute/unlock
//  LOCK_FRAMES  4     consecutive good stereo pairs required to assert locked
// PORTS
//  clk           in   1       audio clock (CLK_AUDIO, 24.576 MHz)
//  reset         in   1       synchronous, active-high
//  i2s_bclk      in   1       async bit clock (data/ws valid on rising edge)
//  i2s_ws        in   1       async word select: 0 = left, 1 = right
//  i2s_data      in   1       async serial data, MSB first
//  sample_l      out  DATA_W  last complete left sample, two's complement
//  sample_r      out  DATA_W  last complete right sample, two's complement
//  sample_valid  out  1       1-cycle pulse when sample_l/sample_r update as a pair
//  locked        out  1       LOCK_FRAMES good pairs received, no error since
//  active        out  1       bclk edge seen within last TIMEOUT_CYC cycles
// BEHAVIOUR
//  - Reset: sample_l = sample_r = 0; sample_valid = locked = active = 0.
//    Synchronizers and debounce go to 0, word inactive, left_hold invalid, counters 0.
//    Reset mid-word aborts the word with no pulse.
//  - Input conditioning: each input goes through a 2-FF synchronizer.
//    Debounced bclk takes the synced level only when the last two synced samples agree.
//    ws/data are sampled from the second sync stage on a debounced bclk rising edge ("edge").
//    bclk high and low phases must each be >= 3 clk; a 1-cycle glitch is rejected.
//  - Bit capture, per edge: if the word is active and bit_cnt < DATA_W, write the sampled data bit
//    to shr[DATA_W-1-bit_cnt], then bit_cnt++. Saturate bit_cnt at DATA_W; drop further bits.
//  - Word boundary: the edge at which ws differs from ws_last (ws sampled at the previous edge).
//    The data bit on that edge is the LSB of the closing word (standard I2S 1-bit delay).
//    Close the word for channel ws_last. Clear shr/bit_cnt. The new word (channel = ws) is active
//    from the next edge.
//  - After reset or timeout the word is inactive until the first boundary; that first partial
//    word is discarded.
//  - Word is "full" iff bit_cnt == DATA_W at close.
//  - Closing left: if full, left_hold <= shr and valid; else left_hold invalid plus error.
//  - Closing right: if full and left_hold valid, sample_l <= left_hold, sample_r <= shr,
//    sample_valid = 1 for one cycle, left_hold invalid, good_cnt++ (saturating).
//    Otherwise: no pulse, error.
//  - Error (short word, or right without left): good_cnt <= 0, locked <= 0.
//  - locked <= 1 in the same cycle good_cnt reaches LOCK_FRAMES.
//  - Latency: sample_valid and the new samples appear exactly 4 clk cycles after the first clk
//    edge that samples the raw bclk rise of the closing-right edge.
//  - Timeout: idle_cnt clears on each edge, increments otherwise, and saturates.
//    When it reaches TIMEOUT_CYC: sample_l = sample_r = 0, locked = 0, active = 0,
//    good_cnt = 0, word inactive, left_hold invalid. active = 1 again on the next edge.
//  - Simultaneous edge + timeout terminal count: the edge wins (idle_cnt clears, no mute).
//  - Outputs are registered and hold their value between pulses.
// TESTING
//  1 Assert reset 3 cycles mid-stream -> all outputs 0 next cycle; no pulse for the aborted word.
//  2 16-bit slots, bclk period 16 clk, L=0x1234 R=0xABCD after an initial ws toggle ->
//    exactly one pulse, 4 clk after the raw bclk rise closing R; sample_l=0x1234, sample_r=0xABCD.
//  3 32-bit slots, L=0x8001 then 16 ones, R=0x7FFF then 16 zeros ->
//    sample_l=0x8001, sample_r=0x7FFF.
//  4 One 12-bit right word -> no pulse, locked=0.
//    Then 4 good pairs -> locked rises in the cycle of the 4th pulse.
//  5 Stop bclk -> exactly 4096 clk after the last edge: sample_l/r=0, locked=0, active=0.
//    Restart -> active=1 on the first edge; first partial word yields no pulse.
//  6 Inject 1-cycle bclk glitches and 1-cycle ws glitches between edges ->
//    captured samples unchanged vs the clean run.

Source files
------------

// File: rtl/mt32_i2s_rx.sv
// mt32_i2s_rx: I2S receiver for the MT32-pi audio path.
// Synchronizes and debounces the async bclk/ws/data pins, assembles left/right
// words, pairs them into stereo samples, and tracks lock and link activity.
module mt32_i2s_rx #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int LOCK_FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i2s_bclk,
    input  logic              i2s_ws,
    input  logic              i2s_data,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    output logic              locked,
    output logic              active
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DATA_W);
    localparam logic [IDLE_W-1:0] IDLE_TERM  = IDLE_W'(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX   = GOOD_W'(LOCK_FRAMES);
    localparam logic [GOOD_W-1:0] GOOD_ALMOST = GOOD_W'(LOCK_FRAMES - 1);

    // input conditioning
    logic bclk_s1, bclk_s2, bclk_s3;
    logic bclk_deb, bclk_deb_d;
    logic ws_s1, ws_s2;
    logic data_s1, data_s2;
    logic bclk_edge;

    // word assembly and pairing state
    logic              word_active;
    logic              ws_last;
    logic [DATA_W-1:0] shr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shr_cap;
    logic [CNT_W-1:0]  cnt_cap;
    logic [DATA_W-1:0] left_hold;
    logic              left_valid;
    logic [GOOD_W-1:0] good_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    // 2-FF synchronizers, plus a third bclk stage feeding the debounce compare
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            ws_s1   <= 1'b0;
            ws_s2   <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            bclk_s1 <= i2s_bclk;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            ws_s1   <= i2s_ws;
            ws_s2   <= ws_s1;
            data_s1 <= i2s_data;
            data_s2 <= data_s1;
        end
    end

    // debounce: follow the synced bclk only when two consecutive samples agree
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_deb   <= 1'b0;
            bclk_deb_d <= 1'b0;
        end else begin
            if (bclk_s2 == bclk_s3) begin
                bclk_deb <= bclk_s2;
            end
            bclk_deb_d <= bclk_deb;
        end
    end

    assign bclk_edge = bclk_deb & ~bclk_deb_d;

    // bit capture for the current edge; shifting in MSB-first places every
    // full word exactly where positional writes would, and short words are
    // never delivered, so the two placements are indistinguishable
    always_comb begin
        shr_cap = shr;
        cnt_cap = bit_cnt;
        if (word_active && (bit_cnt < FULL_CNT)) begin
            shr_cap = {shr[DATA_W-2:0], data_s2};
            cnt_cap = bit_cnt + CNT_W'(1);
        end
    end

    // word boundaries, stereo pairing, lock tracking and idle timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            active       <= 1'b0;
            word_active  <= 1'b0;
            ws_last      <= 1'b0;
            shr          <= '0;
            bit_cnt      <= '0;
            left_hold    <= '0;
            left_valid   <= 1'b0;
            good_cnt     <= '0;
            idle_cnt     <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (bclk_edge) begin
                idle_cnt <= '0;
                active   <= 1'b1;
                ws_last  <= ws_s2;
                if (ws_s2 != ws_last) begin
                    shr         <= '0;
                    bit_cnt     <= '0;
                    word_active <= 1'b1;
                    if (word_active) begin
                        if (!ws_last) begin
                            if (cnt_cap == FULL_CNT) begin
                                left_hold  <= shr_cap;
                                left_valid <= 1'b1;
                            end else begin
                                left_valid <= 1'b0;
                                good_cnt   <= '0;
                                locked     <= 1'b0;
                            end
                        end else begin
                            if ((cnt_cap == FULL_CNT) && left_valid) begin
                                sample_l     <= left_hold;
                                sample_r     <= shr_cap;
                                sample_valid <= 1'b1;
                                left_valid   <= 1'b0;
                                if (good_cnt != GOOD_MAX) begin
                                    good_cnt <= good_cnt + GOOD_W'(1);
                                end
                                if (good_cnt >= GOOD_ALMOST) begin
                                    locked <= 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                                locked   <= 1'b0;
                            end
                        end
                    end
                end else begin
                    shr     <= shr_cap;
                    bit_cnt <= cnt_cap;
                end
            end else if (idle_cnt != IDLE_TERM) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (idle_cnt == IDLE_LAST) begin
                    sample_l    <= '0;
                    sample_r    <= '0;
                    locked      <= 1'b0;
                    active      <= 1'b0;
                    good_cnt    <= '0;
                    word_active <= 1'b0;
                    left_valid  <= 1'b0;
                    shr         <= '0;
                    bit_cnt     <= '0;
                end
            end
        end
    end

endmodule
